// File: rtl/camara_captura_if.sv
// camara_captura_if: camera byte stream, capture config and pixel output bundle
interface camara_captura_if #(
    parameter int ADDR_W = 19
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              capture_en;
    logic              single_shot;
    logic [1:0]        fmt;
    logic              decim;
    logic [15:0]       pixel_data;
    logic              pixel_valid;
    logic [ADDR_W-1:0] pixel_addr;
    logic              line_done;
    logic              frame_done;
    logic              frame_err;
    logic              busy;

    modport master (
        output vsync, href, d, capture_en, single_shot, fmt, decim,
        input  pixel_data, pixel_valid, pixel_addr, line_done, frame_done, frame_err, busy
    );

    modport slave (
        input  vsync, href, d, capture_en, single_shot, fmt, decim,
        output pixel_data, pixel_valid, pixel_addr, line_done, frame_done, frame_err, busy
    );
endinterface

// File: rtl/camara_captura.sv
// camara_captura: frame-synchronised camera byte capture with format conversion and decimation
module camara_captura #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input logic             p_clock,
    input logic             rst,
    camara_captura_if.slave cam
);
    typedef enum logic [1:0] {IDLE, SYNC, WAIT_FRAME, CAPTURE} state_t;

    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam logic [XW-1:0] X_END = XW'(H_RES);
    localparam logic [YW-1:0] Y_END = YW'(V_RES);
    localparam logic [ADDR_W:0] LIM_F = (ADDR_W+1)'(H_RES * V_RES);
    localparam logic [ADDR_W:0] LIM_D = (ADDR_W+1)'((H_RES / 2) * (V_RES / 2));

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              phase_q, phase_d;
    logic [7:0]        b1_q, b1_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [1:0]        fmt_q, fmt_d;
    logic              decim_q, decim_d;
    logic              ss_q, ss_d;
    logic              href_q, href_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              line_q, line_d;
    logic              frame_q, frame_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
    logic [15:0]       pix, conv;
    logic              in_range, keep, room;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        phase_d  = phase_q;
        b1_d     = b1_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fmt_d    = fmt_q;
        decim_d  = decim_q;
        ss_d     = ss_q;
        href_d   = 1'b0;
        data_d   = data_q;
        valid_d  = 1'b0;
        addr_d   = addr_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        ferr_d   = 1'b0;
        pix      = {b1_q, cam.d};
        conv     = fmt_q == 2'd1 ? {8'h00, pix[15:13], pix[10:8], pix[4:3]} :
                   fmt_q == 2'd2 ? {8'h00, b1_q} : pix;
        in_range = x_q < X_END && y_q < Y_END;
        keep     = !decim_q || (!x_q[0] && !y_q[0]);
        room     = {1'b0, cnt_q} < (decim_q ? LIM_D : LIM_F);
        case (state_q)
            IDLE:       state_d = cam.capture_en ? SYNC : IDLE;
            SYNC:       state_d = cam.vsync ? WAIT_FRAME : SYNC;
            WAIT_FRAME: if (!cam.vsync) begin
                state_d = CAPTURE;
                fmt_d   = cam.fmt;
                decim_d = cam.decim;
                ss_d    = cam.single_shot;
                x_d     = '0;
                y_d     = '0;
                phase_d = 1'b0;
                cnt_d   = '0;
                addr_d  = '0;
                err_d   = 1'b0;
            end
            default: begin
                href_d = cam.href;
                if (cam.vsync) begin
                    // a frame cut off mid-line is malformed even if the line count matches
                    frame_d = 1'b1;
                    ferr_d  = err_q || y_q != Y_END || cam.href;
                    state_d = (ss_q || !cam.capture_en) ? IDLE : WAIT_FRAME;
                end else if (cam.href) begin
                    phase_d = !phase_q;
                    if (!phase_q) begin
                        b1_d = cam.d;
                    end else begin
                        x_d = x_q == X_END ? x_q : x_q + 1'b1;
                        if (!in_range) err_d = 1'b1;
                        if (in_range && keep && room) begin
                            valid_d = 1'b1;
                            data_d  = conv;
                            addr_d  = cnt_q;
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end else if (href_q) begin
                    line_d  = 1'b1;
                    y_d     = y_q == Y_END ? y_q : y_q + 1'b1;
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (phase_q || x_q != X_END) err_d = 1'b1;
                end
            end
        endcase
        busy_d = state_d == WAIT_FRAME || state_d == CAPTURE;
    end

    always_ff @(posedge p_clock) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            b1_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fmt_q   <= '0;
            decim_q <= 1'b0;
            ss_q    <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
            b1_q    <= b1_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fmt_q   <= fmt_d;
            decim_q <= decim_d;
            ss_q    <= ss_d;
            href_q  <= href_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign cam.pixel_data  = data_q;
    assign cam.pixel_valid = valid_q;
    assign cam.pixel_addr  = addr_q;
    assign cam.line_done   = line_q;
    assign cam.frame_done  = frame_q;
    assign cam.frame_err   = ferr_q;
    assign cam.busy        = busy_q;
endmodule

// File: tb/tb_camara_captura.sv
// tb_camara_captura: directed scenarios for camara_captura at H_RES=4, V_RES=2
module tb_camara_captura;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    camara_captura_if #(.ADDR_W(3)) bus ();
    camara_captura #(.H_RES(4), .V_RES(2), .ADDR_W(3)) dut (.p_clock(clk), .rst(rst), .cam(bus));

    always #5 clk = ~clk;

    logic [15:0] pd_log[$];
    logic [2:0]  pa_log[$];
    int          ld_n, fd_n, fe_n;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_valid) begin
                pd_log.push_back(bus.pixel_data);
                pa_log.push_back(bus.pixel_addr);
            end
            if (bus.line_done) ld_n++;
            if (bus.frame_done) fd_n++;
            if (bus.frame_err) fe_n++;
        end
    end

    task automatic clear_log();
        pd_log.delete();
        pa_log.delete();
        ld_n = 0;
        fd_n = 0;
        fe_n = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.href = 1'b1;
        bus.d    = b;
        cyc(1);
    endtask

    task automatic end_line();
        bus.href = 1'b0;
        bus.d    = 8'h00;
        cyc(2);
    endtask

    task automatic send_line(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) push_byte(start + 8'(i));
        end_line();
    endtask

    task automatic frame_begin();
        bus.vsync = 1'b1;
        cyc(3);
        bus.vsync = 1'b0;
        cyc(2);
    endtask

    task automatic frame_end();
        bus.vsync = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++;
        if (bus.pixel_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got %h want 0000", bus.pixel_data);
        end
        checks++;
        if (bus.pixel_addr !== 3'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", bus.pixel_addr);
        end
        checks++;
        if ({bus.pixel_valid, bus.line_done, bus.frame_done, bus.frame_err, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000",
                     {bus.pixel_valid, bus.line_done, bus.frame_done, bus.frame_err, bus.busy});
        end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_rgb565();
        logic [15:0] exp_d[4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        bus.capture_en = 1'b1;
        clear_log();
        frame_begin();
        send_line(8'h01, 8);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_capture got %b want 1", bus.busy);
        end
        send_line(8'h01, 8);
        frame_end();
        checks++;
        if (pd_log.size() != 8) begin
            errors++;
            $display("FAIL rgb565_count got %0d want 8", pd_log.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pd_log[i] !== exp_d[i%4] || pa_log[i] !== 3'(i)) begin
                errors++;
                $display("FAIL rgb565_pix%0d got %h@%0d want %h@%0d", i, pd_log[i], pa_log[i], exp_d[i%4], i);
            end
        end
        checks++;
        if (ld_n != 2 || fd_n != 1 || fe_n != 0) begin
            errors++;
            $display("FAIL rgb565_strobes got ld=%0d fd=%0d fe=%0d want 2 1 0", ld_n, fd_n, fe_n);
        end
    endtask

    task automatic test_formats();
        bus.fmt = 2'd1;
        clear_log();
        frame_begin();
        push_byte(8'hF8);
        push_byte(8'h1F);
        bus.fmt = 2'd2;
        push_byte(8'h5A);
        push_byte(8'h80);
        end_line();
        frame_end();
        checks++;
        if (pd_log[0] !== 16'h00E3) begin
            errors++;
            $display("FAIL rgb332 got %h want 00E3", pd_log[0]);
        end
        checks++;
        if (pd_log[1] !== 16'h0048) begin
            errors++;
            $display("FAIL fmt_midframe got %h want 0048", pd_log[1]);
        end
        checks++;
        if (fe_n != 1) begin
            errors++;
            $display("FAIL short_frame_err got %0d want 1", fe_n);
        end
        clear_log();
        frame_begin();
        push_byte(8'h5A);
        push_byte(8'h80);
        end_line();
        frame_end();
        checks++;
        if (pd_log.size() != 1 || pd_log[0] !== 16'h005A) begin
            errors++;
            $display("FAIL y_only got %h n=%0d want 005A n=1", pd_log[0], pd_log.size());
        end
        bus.fmt = 2'd0;
    endtask

    task automatic test_decim();
        bus.decim = 1'b1;
        clear_log();
        frame_begin();
        send_line(8'h11, 8);
        send_line(8'h21, 8);
        frame_end();
        bus.decim = 1'b0;
        checks++;
        if (pd_log.size() != 2) begin
            errors++;
            $display("FAIL decim_count got %0d want 2", pd_log.size());
        end
        checks++;
        if (pd_log[0] !== 16'h1112 || pa_log[0] !== 3'd0) begin
            errors++;
            $display("FAIL decim_pix0 got %h@%0d want 1112@0", pd_log[0], pa_log[0]);
        end
        checks++;
        if (pd_log[1] !== 16'h1516 || pa_log[1] !== 3'd1) begin
            errors++;
            $display("FAIL decim_pix1 got %h@%0d want 1516@1", pd_log[1], pa_log[1]);
        end
        checks++;
        if (fd_n != 1 || fe_n != 0) begin
            errors++;
            $display("FAIL decim_frame got fd=%0d fe=%0d want 1 0", fd_n, fe_n);
        end
    endtask

    task automatic test_short_line();
        clear_log();
        frame_begin();
        send_line(8'h01, 7);
        send_line(8'h01, 8);
        frame_end();
        checks++;
        if (pd_log.size() != 7) begin
            errors++;
            $display("FAIL odd_line_count got %0d want 7", pd_log.size());
        end
        checks++;
        if (pd_log[3] !== 16'h0102 || pa_log[3] !== 3'd3) begin
            errors++;
            $display("FAIL odd_line_next got %h@%0d want 0102@3", pd_log[3], pa_log[3]);
        end
        checks++;
        if (ld_n != 2 || fd_n != 1 || fe_n != 1) begin
            errors++;
            $display("FAIL odd_line_strobes got ld=%0d fd=%0d fe=%0d want 2 1 1", ld_n, fd_n, fe_n);
        end
    endtask

    task automatic test_vsync_in_line();
        clear_log();
        frame_begin();
        send_line(8'h01, 8);
        push_byte(8'h01);
        push_byte(8'h02);
        bus.vsync = 1'b1;
        cyc(1);
        bus.href = 1'b0;
        cyc(2);
        checks++;
        if (ld_n != 1 || fd_n != 1 || fe_n != 1 || pd_log.size() != 5) begin
            errors++;
            $display("FAIL vsync_in_line got ld=%0d fd=%0d fe=%0d n=%0d want 1 1 1 5",
                     ld_n, fd_n, fe_n, pd_log.size());
        end
    endtask

    task automatic test_single_shot();
        bit found = 1'b0;
        bit busy_at_done = 1'b1;
        bus.single_shot = 1'b1;
        clear_log();
        frame_begin();
        send_line(8'h01, 8);
        send_line(8'h01, 8);
        bus.vsync = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                found = 1'b1;
                busy_at_done = bus.busy;
            end
        end
        bus.capture_en = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ss_done_timeout got none want frame_done");
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL ss_idle_busy got %b want 0", busy_at_done);
        end
        cyc(2);
        for (int f = 0; f < 2; f++) begin
            frame_begin();
            send_line(8'h01, 8);
            send_line(8'h01, 8);
            frame_end();
        end
        checks++;
        if (fd_n != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ss_frames got fd=%0d busy=%b want 1 0", fd_n, bus.busy);
        end
        bus.single_shot = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.capture_en = 1'b1;
        frame_begin();
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        rst = 1'b1;
        cyc(2);
        checks++;
        if (bus.pixel_valid !== 1'b0 || bus.pixel_addr !== 3'd0 || bus.pixel_data !== 16'h0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b a=%0d d=%h want 0 0 0",
                     bus.pixel_valid, bus.pixel_addr, bus.pixel_data);
        end
        rst = 1'b0;
        clear_log();
        for (int i = 5; i <= 8; i++) push_byte(8'(i));
        end_line();
        send_line(8'h01, 8);
        checks++;
        if (pd_log.size() != 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d pixels want 0", pd_log.size());
        end
        frame_end();
        checks++;
        if (fd_n != 0) begin
            errors++;
            $display("FAIL midrst_no_done got %0d want 0", fd_n);
        end
        frame_begin();
        send_line(8'h01, 8);
        checks++;
        if (pd_log.size() != 4 || pd_log[0] !== 16'h0102 || pa_log[0] !== 3'd0) begin
            errors++;
            $display("FAIL midrst_restart got %h@%0d n=%0d want 0102@0 n=4", pd_log[0], pa_log[0], pd_log.size());
        end
    endtask

    initial begin
        bus.vsync       = 1'b0;
        bus.href        = 1'b0;
        bus.d           = 8'h00;
        bus.capture_en  = 1'b0;
        bus.single_shot = 1'b0;
        bus.fmt         = 2'd0;
        bus.decim       = 1'b0;
        clear_log();
        test_reset();
        test_rgb565();
        test_formats();
        test_decim();
        test_short_line();
        test_vsync_in_line();
        test_single_shot();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/camara_captura.md
CAMARA_CAPTURA -- requirements
Module: camara_captura

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, pixel_addr width; SHALL satisfy 2^ADDR_W >= H_RES*V_RES.
REQ-004 p_clock  in  1  camera pixel clock; sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 vsync  in  1  frame sync; high = vertical blanking.
REQ-007 href  in  1  line valid; high = active bytes on d.
REQ-008 d  in  8  camera data byte.
REQ-009 capture_en  in  1  enables capture; sampled only at frame start.
REQ-010 single_shot  in  1  1 = stop after one frame; sampled at frame start.
REQ-011 fmt  in  2  0 = RGB565 passthrough, 1 = RGB332, 2 = Y only (YUYV), 3 = reserved, treated as 0.
REQ-012 decim  in  1  1 = 2x2 subsample; sampled at frame start.
REQ-013 pixel_data  out  16  assembled/converted pixel.
REQ-014 pixel_valid  out  1  one-cycle strobe; pixel_data/pixel_addr valid.
REQ-015 pixel_addr  out  ADDR_W  linear output address of the pixel.
REQ-016 line_done  out  1  one-cycle strobe at end of each active line.
REQ-017 frame_done  out  1  one-cycle strobe at end of frame.
REQ-018 frame_err  out  1  one-cycle strobe coincident with frame_done when the frame was malformed.
REQ-019 busy  out  1  high in states WAIT_FRAME and CAPTURE.

Function
REQ-020 States: IDLE, SYNC, WAIT_FRAME, CAPTURE; all outputs registered.
REQ-021 IDLE: capture_en=1 -> SYNC.
REQ-022 SYNC: vsync=1 -> WAIT_FRAME; no capture begins mid-frame.
REQ-023 WAIT_FRAME: vsync=0 -> CAPTURE; on that edge latch fmt, decim, single_shot; clear x, y, byte phase, pixel_addr, error flag.
REQ-024 CAPTURE: vsync=1 -> pulse frame_done (plus frame_err if flagged); next state IDLE if latched single_shot=1 or capture_en=0, else WAIT_FRAME.
REQ-025 Bytes are captured only while href=1 in CAPTURE; each pixel is two bytes, first byte high, second byte low.
REQ-026 The edge sampling a pixel's second byte registers pixel_data and pixel_valid=1, both visible the following cycle.
REQ-027 fmt 0: pixel_data = {b1,b2}; fmt 1: pixel_data = {8'h00, R[4:2], G[5:3], B[4:3]} of RGB565 {b1,b2}; fmt 2: pixel_data = {8'h00, b1}.
REQ-028 Source x counts pixels within a line, y counts lines; decim=1 emits only pixels with x and y both even.
REQ-029 pixel_addr starts at 0 each frame and increments by 1 after each emitted pixel; no multiplier.
REQ-030 Pixels with x >= H_RES or lines with y >= V_RES are not emitted and set the error flag; pixel_addr never exceeds (H_RES>>decim)*(V_RES>>decim)-1.
REQ-031 href falling edge in CAPTURE: pulse line_done, y+1, x and byte phase cleared; an odd dangling byte is discarded and sets the error flag.
REQ-032 A line with x != H_RES at href fall, or a frame with y != V_RES at vsync rise, sets the error flag.
REQ-033 Config inputs changed mid-frame take effect only at the next frame start.
REQ-034 vsync rising while href=1: frame ends, line_done not pulsed, error flag set.

Reset
REQ-035 rst=1 at any edge: state IDLE; pixel_data=0, pixel_valid=0, pixel_addr=0, line_done=0, frame_done=0, frame_err=0, busy=0; counters, phase and latched config cleared.
REQ-036 rst mid-frame discards the frame without frame_done; after release, capture restarts via SYNC.

Verification (H_RES=4, V_RES=2)
REQ-037 fmt=0, decim=0, 2 lines x 8 bytes 0x01..0x08 -> pixel_data 0x0102, 0x0304, 0x0506, 0x0708 at addr 0..3 per line, addr 4..7 line 2; one frame_done, frame_err=0.
REQ-038 fmt=1, bytes {0xF8,0x1F} -> pixel_data 0x00E3; fmt=2, bytes {0x5A,0x80} -> 0x005A.
REQ-039 decim=1, 2 lines x 4 pixels -> exactly 2 valid pixels, addr 0 and 1, both from line 0.
REQ-040 Line with 7 bytes -> 3 pixels, line_done pulses, frame_err=1 with frame_done.
REQ-041 single_shot=1, three frames driven -> exactly one frame_done, then busy=0 in IDLE.
REQ-042 rst pulsed after pixel 2 of line 0, bench starts mid-frame (vsync=0) -> no pixel_valid until a full vsync high-then-low cycle, then addr restarts at 0.
